// File: rtl/systolic_mm_engine_if.sv
// Operand/result handshake bundle for systolic_mm_engine.
// master = operand fetch + result writeback side, slave = engine.
interface systolic_mm_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int N          = 3,
    parameter int M          = 3,
    parameter int K_MAX      = 256
);
    logic                          start;
    logic [$clog2(K_MAX+1)-1:0]    k_len;
    logic                          in_valid;
    logic                          in_ready;
    logic [N*DATA_WIDTH-1:0]       a_vec;
    logic [M*DATA_WIDTH-1:0]       b_vec;
    logic                          out_valid;
    logic                          out_ready;
    logic [M*ACC_WIDTH-1:0]        out_data;
    logic                          out_last;
    logic                          busy;

    modport master (
        output start, k_len, in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  start, k_len, in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// N x M output-stationary systolic C = A x B; SYSTOLIC_MM_SATURATE_EN selects saturating accumulators.
// Latency: k_len beats + N+M-2 flush cycles, row 0 valid the cycle after the last MAC.
// Backpressure: in_valid low freezes the whole array; out_ready low holds the current row.
module systolic_mm_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int N          = 3,
    parameter int M          = 3,
    parameter int K_MAX      = 256
) (
    input logic                 clk,
    input logic                 rst,
    systolic_mm_engine_if.slave io
);
    localparam int DW        = DATA_WIDTH;
    localparam int AW        = ACC_WIDTH;
    localparam int KW        = $clog2(K_MAX + 1);
    localparam int FLUSH_CYC = N + M - 2;
    localparam int FW        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;
    localparam int RW        = (N > 1) ? $clog2(N) : 1;
    localparam int NA        = (N > 1) ? N * (N - 1) / 2 : 1;
    localparam int MA        = (M > 1) ? M * (M - 1) / 2 : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    // Skew delay lines are packed triangularly: lane i owns i entries starting at tri_off(i).
    function automatic int tri_off(input int i);
        return (i * (i - 1)) / 2;
    endfunction

    function automatic logic signed [AW-1:0] mac(input logic signed [AW-1:0] acc,
                                                 input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] prod;
        prod = (2*DW)'(a) * (2*DW)'(b);
`ifdef SYSTOLIC_MM_SATURATE_EN
        begin
            logic signed [AW:0] sum;
            sum = (AW+1)'(acc) + (AW+1)'(prod);
            if (sum[AW] != sum[AW-1])
                return sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            return sum[AW-1:0];
        end
`else
        return acc + AW'(prod);
`endif
    endfunction

    state_t                state_q, state_d;
    logic [KW-1:0]         k_len_q, k_len_d, beat_q, beat_d;
    logic [FW-1:0]         flush_q, flush_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  en, clr;

    logic signed [DW-1:0]  skew_a_q [NA], skew_a_d [NA];
    logic signed [DW-1:0]  skew_b_q [MA], skew_b_d [MA];
    logic signed [DW-1:0]  a_q [N][M], a_d [N][M], b_q [N][M], b_d [N][M];
    logic signed [AW-1:0]  acc_q [N][M], acc_d [N][M];
    logic signed [DW-1:0]  a_lane [N], b_lane [M], a_skew [N], b_skew [M];
    logic signed [DW-1:0]  a_in [N][M], b_in [N][M];

    logic                  in_ready_q, in_ready_d, busy_q, busy_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [M*AW-1:0]       out_data_q, out_data_d;

    for (genvar i = 0; i < N; i++) begin : g_a_lane
        assign a_lane[i] = (state_q == STREAM) ? io.a_vec[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_skew[i] = a_lane[i];
        end else begin : g_delay
            assign a_skew[i] = skew_a_q[tri_off(i) + i - 1];
        end
    end

    for (genvar j = 0; j < M; j++) begin : g_b_lane
        assign b_lane[j] = (state_q == STREAM) ? io.b_vec[j*DW +: DW] : '0;
        if (j == 0) begin : g_direct
            assign b_skew[j] = b_lane[j];
        end else begin : g_delay
            assign b_skew[j] = skew_b_q[tri_off(j) + j - 1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < M; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_skew[i];
            end else begin : g_a_hop
                assign a_in[i][j] = a_q[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b_skew[j];
            end else begin : g_b_hop
                assign b_in[i][j] = b_q[i-1][j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        en      = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (io.start) begin
                k_len_d = io.k_len;
                beat_d  = '0;
                flush_d = '0;
                row_d   = '0;
                clr     = 1'b1;
                state_d = (io.k_len == '0) ? DRAIN : STREAM;
            end
            STREAM: if (io.in_valid) begin
                en     = 1'b1;
                beat_d = beat_q + KW'(1);
                if (beat_q == k_len_q - KW'(1))
                    state_d = (FLUSH_CYC == 0) ? DRAIN : FLUSH;
            end
            FLUSH: begin
                en      = 1'b1;
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(FLUSH_CYC - 1))
                    state_d = DRAIN;
            end
            DRAIN: if (io.out_ready) begin
                if (row_q == RW'(N - 1))
                    state_d = IDLE;
                else
                    row_d = row_q + RW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        skew_a_d = skew_a_q;
        skew_b_d = skew_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        if (clr) begin
            skew_a_d = '{default: '0};
            skew_b_d = '{default: '0};
            a_d      = '{default: '0};
            b_d      = '{default: '0};
            acc_d    = '{default: '0};
        end else if (en) begin
            for (int i = 1; i < N; i++) begin
                skew_a_d[tri_off(i)] = a_lane[i];
                for (int d = 1; d < i; d++)
                    skew_a_d[tri_off(i) + d] = skew_a_q[tri_off(i) + d - 1];
            end
            for (int j = 1; j < M; j++) begin
                skew_b_d[tri_off(j)] = b_lane[j];
                for (int d = 1; d < j; d++)
                    skew_b_d[tri_off(j) + d] = skew_b_q[tri_off(j) + d - 1];
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < M; j++) begin
                    a_d[i][j]   = a_in[i][j];
                    b_d[i][j]   = b_in[i][j];
                    acc_d[i][j] = mac(acc_q[i][j], a_in[i][j], b_in[i][j]);
                end
            end
        end
    end

    // Outputs are registered from next-state so they line up with state_q.
    always_comb begin
        in_ready_d  = (state_d == STREAM);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DRAIN);
        out_last_d  = (state_d == DRAIN) && (row_d == RW'(N - 1));
        out_data_d  = '0;
        if (state_d == DRAIN) begin
            for (int j = 0; j < M; j++)
                out_data_d[j*AW +: AW] = acc_d[row_d][j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            beat_q      <= '0;
            flush_q     <= '0;
            row_q       <= '0;
            skew_a_q    <= '{default: '0};
            skew_b_q    <= '{default: '0};
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            acc_q       <= '{default: '0};
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            row_q       <= row_d;
            skew_a_q    <= skew_a_d;
            skew_b_q    <= skew_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.busy      = busy_q;
    assign io.out_valid = out_valid_q;
    assign io.out_last  = out_last_q;
    assign io.out_data  = out_data_q;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine (3x3, 16-bit operands, 32-bit accumulators).
module tb_systolic_mm_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_mm_engine_if #(.DATA_WIDTH(16), .ACC_WIDTH(32), .N(3), .M(3), .K_MAX(256)) io ();

    systolic_mm_engine #(.DATA_WIDTH(16), .ACC_WIDTH(32), .N(3), .M(3), .K_MAX(256)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    logic [15:0] mat_a [3][4];
    logic [15:0] mat_b [4][3];
    logic [31:0] exp_c [3][3];
    int n_assert = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    always @(negedge clk) if (io.out_valid && io.out_ready) hs_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input int r);
        for (int j = 0; j < 3; j++)
            check($sformatf("%s_r%0d_c%0d", tag, r, j), io.out_data[j*32 +: 32], exp_c[r][j]);
    endtask

    task automatic fill(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] cv);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                mat_a[i][k] = av;
                mat_b[k][i] = bv;
            end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) exp_c[i][j] = cv;
    endtask

    task automatic fill_identity();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                mat_a[i][k] = (i == k) ? 16'd1 : 16'd0;
                mat_b[k][i] = 16'd0;
            end
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) mat_b[k][j] = 16'(3*k + j + 1);
        exp_c = '{'{32'd1, 32'd2, 32'd3}, '{32'd4, 32'd5, 32'd6}, '{32'd7, 32'd8, 32'd9}};
    endtask

    task automatic start_op(input int k);
        io.start = 1'b1;
        io.k_len = 9'(k);
        tick();
        io.start = 1'b0;
    endtask

    task automatic feed(input string tag, input int k, input bit stall);
        for (int kk = 0; kk < k; kk++) begin
            if (stall && kk > 0) begin
                io.in_valid = 1'b0;
                io.a_vec    = 48'hDEAD_BEEF_CAFE;
                io.b_vec    = 48'h1234_5678_9ABC;
                io.start    = 1'b1;
                io.k_len    = '0;
                tick();
                io.start    = 1'b0;
            end
            check({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
            for (int i = 0; i < 3; i++) io.a_vec[i*16 +: 16] = mat_a[i][kk];
            for (int j = 0; j < 3; j++) io.b_vec[j*16 +: 16] = mat_b[kk][j];
            io.in_valid = 1'b1;
            tick();
        end
        io.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int cyc;
        cyc = 0;
        while (io.out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_out_valid_rise"}, 32'(io.out_valid), 32'd1);
    endtask

    task automatic drain(input string tag, input bit bp);
        int hs0;
        hs0 = hs_cnt;
        for (int r = 0; r < 3; r++) begin
            if (bp && r == 1) begin
                io.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check({tag, "_hold_valid"}, 32'(io.out_valid), 32'd1);
                    check({tag, "_hold_last"}, 32'(io.out_last), 32'd0);
                    check_row({tag, "_hold"}, 1);
                end
                io.out_ready = 1'b1;
            end
            check($sformatf("%s_valid_r%0d", tag, r), 32'(io.out_valid), 32'd1);
            check($sformatf("%s_last_r%0d", tag, r), 32'(io.out_last), (r == 2) ? 32'd1 : 32'd0);
            check($sformatf("%s_in_ready_r%0d", tag, r), 32'(io.in_ready), 32'd0);
            check_row(tag, r);
            tick();
        end
        check({tag, "_busy_after"}, 32'(io.busy), 32'd0);
        check({tag, "_valid_after"}, 32'(io.out_valid), 32'd0);
        check({tag, "_handshakes"}, 32'(hs_cnt - hs0), 32'd3);
    endtask

    task automatic run_case(input string tag, input int k, input bit stall, input bit bp);
        start_op(k);
        feed(tag, k, stall);
        wait_out(tag);
        drain(tag, bp);
    endtask

    initial begin
        rst          = 1'b0;
        io.start     = 1'b0;
        io.k_len     = '0;
        io.in_valid  = 1'b0;
        io.a_vec     = '0;
        io.b_vec     = '0;
        io.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(io.busy), 32'd0);
        check("rst_in_ready", 32'(io.in_ready), 32'd0);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_out_last", 32'(io.out_last), 32'd0);
        for (int j = 0; j < 3; j++) check($sformatf("rst_out_data_c%0d", j), io.out_data[j*32 +: 32], 32'd0);
        rst = 1'b1;
        tick();

        fill_identity();
        run_case("ident", 3, 1'b0, 1'b0);
        run_case("stall", 3, 1'b1, 1'b0);

        fill(16'd2, 16'd3, 32'd18);
        run_case("bp", 3, 1'b0, 1'b1);

        fill(16'd0, 16'd0, 32'd0);
        start_op(0);
        check("zero_out_valid_now", 32'(io.out_valid), 32'd1);
        drain("zero", 1'b0);

        fill(16'hFFFF, 16'd3, 32'hFFFF_FFF7);
        run_case("signed", 3, 1'b0, 1'b0);

        fill_identity();
        mat_a[0][0] = 16'd7;
        mat_b[0][2] = 16'd11;
        start_op(3);
        feed("abort", 3, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("abort_busy", 32'(io.busy), 32'd0);
        check("abort_in_ready", 32'(io.in_ready), 32'd0);
        check("abort_out_valid", 32'(io.out_valid), 32'd0);
        check("abort_out_last", 32'(io.out_last), 32'd0);
        for (int j = 0; j < 3; j++) check($sformatf("abort_out_data_c%0d", j), io.out_data[j*32 +: 32], 32'd0);
        tick();
        rst = 1'b1;
        tick();
        fill_identity();
        run_case("post_rst", 3, 1'b0, 1'b0);

`ifdef SYSTOLIC_MM_SATURATE_EN
        fill(16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF);
`else
        fill(16'h7FFF, 16'h7FFF, 32'hFFFC_0004);
`endif
        run_case("sat", 4, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
